alu_cmd_sequencer: RTL and testbench
====================================

// Module: alu_cmd_sequencer
// PURPOSE
//  Initiator-side controller for the 4-bit combinational ALU (opcode 00=ADD, 01=SUB, 10=AND, 11=OR).
//  - Queues operand/opcode commands in a small FIFO.
//  - Drives one command at a time onto the ALU input port from registers.
//  - Captures alu_result and returns it in order over a valid/ready response channel.
//  - Sits between the test/stimulus master and the ALU instance.
// PARAMETERS
//  WIDTH  4  operand/result width; must match the ALU instance
//  DEPTH  4  command FIFO entries; power of 2, >= 2
// PORTS
//  clk         in   1      single clock, all logic rising-edge
//  rst         in   1      synchronous, active-high reset
//  cmd_valid   in   1      command present
//  cmd_ready   out  1      FIFO can accept; = !full, forced 0 while rst=1
//  cmd_a       in   WIDTH  operand A
//  cmd_b       in   WIDTH  operand B
//  cmd_op      in   2      opcode
//  alu_a       out  WIDTH  to ALU A (registered)
//  alu_b       out  WIDTH  to ALU B (registered)
//  alu_opcode  out  2      to ALU opcode (registered)
//  alu_result  in   WIDTH  from ALU result (combinational)
//  rsp_valid   out  1      response present
//  rsp_ready   in   1      response accepted
//  rsp_result  out  WIDTH  captured result
//  rsp_op      out  2      opcode of the command that produced rsp_result
//  busy        out  1      1 when FIFO non-empty or FSM not IDLE
// BEHAVIOUR
//  Reset (one clk edge with rst=1):
//  - FIFO pointers/count cleared; FSM -> IDLE.
//  - alu_a/alu_b/alu_opcode/rsp_result/rsp_op = 0; rsp_valid = 0; busy = 0.
//  Command push: occurs on an edge where cmd_valid && cmd_ready.
//  - When full, cmd_ready = 0. It does not look ahead to a same-cycle pop.
//  FSM states IDLE -> ISSUE -> RESPOND -> IDLE:
//  - IDLE: if FIFO non-empty, pop head into alu_a/alu_b/alu_opcode, go ISSUE. Otherwise hold.
//  - ISSUE: one cycle with stable ALU inputs. At the edge, rsp_result <= alu_result,
//    rsp_op <= alu_opcode, rsp_valid <= 1, go RESPOND.
//  - RESPOND: hold rsp_* stable while rsp_ready = 0. On rsp_valid && rsp_ready,
//    rsp_valid <= 0, go IDLE.
//  Timing:
//  - Latency: command accepted at edge E0 -> rsp_valid high after E2, given an empty FIFO and IDLE FSM.
//  - Throughput: at most 1 response per 3 cycles.
//  - alu_* keep the last issued values until the next pop. They are not cleared after a response.
//  - Push and pop in the same cycle are both honoured; count unchanged.
//  - Pointers wrap modulo DEPTH. Full/empty are derived from a log2(DEPTH)+1-bit count.
//  - Capacity with backpressure: 1 in-flight command + DEPTH queued.
//  - Responses are returned strictly in acceptance order. No command is dropped except by reset.
//  - Reset mid-operation: queued and in-flight commands are discarded silently, rsp_valid drops
//    at the reset edge, and no stale response appears afterwards.
// CONFIGURATION
//  ALU_FLAGS_EN defined: adds ports rsp_zero (out 1) and rsp_carry (out 1), captured with rsp_result.
//  - rsp_zero = (alu_result == 0).
//  - rsp_carry = carry-out of alu_a+alu_b for ADD; borrow (alu_a < alu_b) for SUB; 0 for AND/OR.
//  - Computed internally on WIDTH+1 bits; both reset to 0.
//  ALU_FLAGS_EN undefined: ports and flag logic are absent; all other behaviour is identical.
// TESTING
//  1. rst=1 for 2 clk -> rsp_valid=0, busy=0, alu_*=0, cmd_ready=0 during rst, then 1 after release.
//  2. ADD A=7,B=5, rsp_ready=1 -> rsp_result=4'hC, rsp_op=00, valid 2 cycles after acceptance
//     [flags: zero=0, carry=0].
//  3. SUB 3-5 -> 4'hE [carry=1]; ADD 9+7 -> 4'h0 [zero=1, carry=1].
//  4. AND A=4'hC,B=4'hA -> 4'h8; OR same operands -> 4'hE; rsp_op matches each command.
//  5. rsp_ready=0, push 6 commands with DEPTH=4 -> 5 accepted, 6th sees cmd_ready=0.
//     Then rsp_ready=1 -> 5 responses in order, busy falls after the last.
//  6. rst asserted while in RESPOND with 3 queued -> rsp_valid=0 next cycle; no responses afterwards.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// Command FIFO + IDLE/ISSUE/RESPOND sequencer driving a combinational 4-bit ALU.
// Optional `ALU_FLAGS_EN adds rsp_zero/rsp_carry, captured alongside rsp_result.
module alu_cmd_sequencer #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [1:0]       cmd_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_opcode,
  input  logic [WIDTH-1:0] alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [1:0]       rsp_op,
`ifdef ALU_FLAGS_EN
  output logic             rsp_zero,
  output logic             rsp_carry,
`endif
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   C_FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   C_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] P_ONE   = AW'(1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_RESPOND = 2'd2;

  logic [WIDTH-1:0] r_mem_a  [DEPTH];
  logic [WIDTH-1:0] r_mem_b  [DEPTH];
  logic [1:0]       r_mem_op [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [1:0]       r_state;

  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [1:0]       r_alu_op;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_result;
  logic [1:0]       r_rsp_op;

  logic w_push;
  logic w_pop;
  logic w_empty;

  assign w_empty   = (r_count == '0);
  // Ready reflects only the current fill level; a same-cycle pop does not free a slot early.
  assign cmd_ready = !rst && (r_count != C_FULL);
  assign w_push    = cmd_valid && cmd_ready;
  assign w_pop     = (r_state == S_IDLE) && !w_empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_a[r_wr_ptr]  <= cmd_a;
      r_mem_b[r_wr_ptr]  <= cmd_b;
      r_mem_op[r_wr_ptr] <= cmd_op;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + P_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + P_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + C_ONE;
        2'b01:   r_count <= r_count - C_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef ALU_FLAGS_EN
  logic [WIDTH:0] w_sum;
  logic           w_carry;
  logic           r_rsp_zero;
  logic           r_rsp_carry;

  assign w_sum = {1'b0, r_alu_a} + {1'b0, r_alu_b};
  always_comb begin
    w_carry = 1'b0;
    case (r_alu_op)
      2'b00:   w_carry = w_sum[WIDTH];
      2'b01:   w_carry = (r_alu_a < r_alu_b);
      default: w_carry = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_zero  <= 1'b0;
      r_rsp_carry <= 1'b0;
    end else if (r_state == S_ISSUE) begin
      r_rsp_zero  <= (alu_result == '0);
      r_rsp_carry <= w_carry;
    end
  end

  assign rsp_zero  = r_rsp_zero;
  assign rsp_carry = r_rsp_carry;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_op     <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_op     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_alu_a  <= r_mem_a[r_rd_ptr];
            r_alu_b  <= r_mem_b[r_rd_ptr];
            r_alu_op <= r_mem_op[r_rd_ptr];
            r_state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_rsp_result <= alu_result;
          r_rsp_op     <= r_alu_op;
          r_rsp_valid  <= 1'b1;
          r_state      <= S_RESPOND;
        end
        S_RESPOND: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_opcode = r_alu_op;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign rsp_op     = r_rsp_op;
  assign busy       = !w_empty || (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: table of single commands, backpressure fill, mid-run reset.
// A behavioural ALU closes the loop; define ALU_FLAGS_EN to also check the flag outputs.
module tb_alu_cmd_sequencer;
  localparam int WIDTH = 4;
  localparam int DEPTH = 4;

  logic             clk;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [1:0]       alu_opcode;
  logic [WIDTH-1:0] alu_result;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic [1:0]       rsp_op;
  logic             busy;
`ifdef ALU_FLAGS_EN
  logic             rsp_zero;
  logic             rsp_carry;
`endif

  alu_cmd_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_op(rsp_op),
`ifdef ALU_FLAGS_EN
    .rsp_zero(rsp_zero), .rsp_carry(rsp_carry),
`endif
    .busy(busy)
  );

  // Stand-in for the combinational ALU instance.
  always_comb begin
    alu_result = '0;
    case (alu_opcode)
      2'b00: alu_result = alu_a + alu_b;
      2'b01: alu_result = alu_a - alu_b;
      2'b10: alu_result = alu_a & alu_b;
      2'b11: alu_result = alu_a | alu_b;
      default: alu_result = '0;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] res;
    logic [1:0] op;
    logic       z;
    logic       c;
  } exp_t;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
    exp_t       e;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  int   n_rsp  = 0;
  exp_t sb_q[$];
  exp_t drv_exp;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t model(input int a, input int b, input int op);
    exp_t e;
    int   r;
    logic c;
    c = 1'b0;
    case (op)
      0: begin r = a + b; c = (r > 15); end
      1: begin r = a - b; c = (a < b); end
      2: r = a & b;
      default: r = a | b;
    endcase
    r     = r & 15;
    e.res = 4'(r);
    e.op  = 2'(op);
    e.z   = (r == 0);
    e.c   = c;
    return e;
  endfunction

  // One clock: record accepted commands and check handshaken responses at the falling edge,
  // then return 1 time unit after the next rising edge, where inputs are driven.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (cmd_valid && cmd_ready) sb_q.push_back(drv_exp);
    if (rsp_valid && rsp_ready) begin
      n_rsp++;
      if (sb_q.size() == 0) begin
        chk("unexpected_rsp", {28'd0, rsp_result}, 32'hFFFF_FFFF);
      end else begin
        e = sb_q.pop_front();
        $display("rsp #%0d: result=%h op=%0d (expect %h/%0d)", n_rsp, rsp_result, rsp_op, e.res, e.op);
        chk("rsp_result", {28'd0, rsp_result}, {28'd0, e.res});
        chk("rsp_op", {30'd0, rsp_op}, {30'd0, e.op});
`ifdef ALU_FLAGS_EN
        chk("rsp_zero", {31'd0, rsp_zero}, {31'd0, e.z});
        chk("rsp_carry", {31'd0, rsp_carry}, {31'd0, e.c});
`endif
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int g;
    g = 0;
    while (sb_q.size() != 0 && g < budget) begin
      tick();
      g++;
    end
    if (sb_q.size() != 0) chk("drain_timeout", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic send_one(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op, input exp_t e);
    int g;
    int lat;
    cmd_a = a; cmd_b = b; cmd_op = op; drv_exp = e; cmd_valid = 1'b1;
    g = 0;
    while (!cmd_ready && g < 20) begin
      tick();
      g++;
    end
    if (!cmd_ready) chk("accept_timeout", 32'(g), 32'd0);
    tick();
    cmd_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 10) begin
      tick();
      lat++;
    end
    chk("latency", 32'(lat), 32'd2);
    drain(10);
    chk("busy_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e0;
    int   seen;
    vecs[0] = '{a: 4'h7, b: 4'h5, op: 2'b00, e: '{res: 4'hC, op: 2'b00, z: 1'b0, c: 1'b0}};
    vecs[1] = '{a: 4'h3, b: 4'h5, op: 2'b01, e: '{res: 4'hE, op: 2'b01, z: 1'b0, c: 1'b1}};
    vecs[2] = '{a: 4'h9, b: 4'h7, op: 2'b00, e: '{res: 4'h0, op: 2'b00, z: 1'b1, c: 1'b1}};
    vecs[3] = '{a: 4'hC, b: 4'hA, op: 2'b10, e: '{res: 4'h8, op: 2'b10, z: 1'b0, c: 1'b0}};
    vecs[4] = '{a: 4'hC, b: 4'hA, op: 2'b11, e: '{res: 4'hE, op: 2'b11, z: 1'b0, c: 1'b0}};
    vecs[5] = '{a: 4'h5, b: 4'h3, op: 2'b01, e: '{res: 4'h2, op: 2'b01, z: 1'b0, c: 1'b0}};
    vecs[6] = '{a: 4'h5, b: 4'hA, op: 2'b10, e: '{res: 4'h0, op: 2'b10, z: 1'b1, c: 1'b0}};
    vecs[7] = '{a: 4'hF, b: 4'h1, op: 2'b00, e: '{res: 4'h0, op: 2'b00, z: 1'b1, c: 1'b1}};

    rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_a = '0; cmd_b = '0; cmd_op = '0; drv_exp = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_alu_a", {28'd0, alu_a}, 32'd0);
    chk("rst_alu_b", {28'd0, alu_b}, 32'd0);
    chk("rst_alu_op", {30'd0, alu_opcode}, 32'd0);
    chk("rst_rsp_result", {28'd0, rsp_result}, 32'd0);
    chk("rst_rsp_op", {30'd0, rsp_op}, 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      $display("vec %0d: a=%h b=%h op=%0d", i, vecs[i].a, vecs[i].b, vecs[i].op);
      send_one(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].e);
      chk("alu_a_held", {28'd0, alu_a}, {28'd0, vecs[i].a});
    end

    // Backpressure: one in flight plus DEPTH queued, the sixth must be refused.
    rsp_ready = 1'b0;
    n_rsp = 0;
    for (int i = 0; i < 6; i++) begin
      cmd_a = 4'(i + 1); cmd_b = 4'(2 * i); cmd_op = 2'(i % 4);
      drv_exp = model(i + 1, 2 * i, i % 4);
      cmd_valid = 1'b1;
      if (i < 5) begin
        chk("fill_ready", {31'd0, cmd_ready}, 32'd1);
        tick();
      end else begin
        chk("full_ready", {31'd0, cmd_ready}, 32'd0);
      end
    end
    for (int i = 0; i < 3; i++) tick();
    chk("full_ready_held", {31'd0, cmd_ready}, 32'd0);
    chk("stall_valid", {31'd0, rsp_valid}, 32'd1);
    e0 = model(1, 0, 0);
    chk("stall_result", {28'd0, rsp_result}, {28'd0, e0.res});
    chk("stall_queue", 32'(sb_q.size()), 32'd5);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    drain(60);
    chk("bp_rsp_count", 32'(n_rsp), 32'd5);
    chk("bp_busy_done", {31'd0, busy}, 32'd0);

    // Reset while in RESPOND with three commands still queued.
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cmd_a = 4'(i + 3); cmd_b = 4'(i); cmd_op = 2'(i % 4);
      drv_exp = model(i + 3, i, i % 4);
      cmd_valid = 1'b1;
      tick();
    end
    cmd_valid = 1'b0;
    tick();
    chk("pre_rst_valid", {31'd0, rsp_valid}, 32'd1);
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    sb_q.delete();
    rst = 1'b0;
    rsp_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      if (rsp_valid) seen++;
      tick();
    end
    chk("stale_rsp", 32'(seen), 32'd0);
    chk("post_mid_rst_busy", {31'd0, busy}, 32'd0);

    send_one(4'h1, 4'h1, 2'b00, model(1, 1, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
